// File: rtl/arty_z7_led_pkg.sv
// Shared types and helpers for the Arty Z7 LED core.
package arty_z7_led_pkg;

    typedef enum logic [1:0] {
        LED_OFF_E     = 2'd0,
        LED_ON_E      = 2'd1,
        LED_BLINK_E   = 2'd2,
        LED_BREATHE_E = 2'd3
    } led_mode_t;

    // Mode cycle used on every toggle edge: OFF -> ON -> BLINK -> BREATHE -> OFF.
    function automatic led_mode_t next_mode(input led_mode_t cur);
        case (cur)
            LED_OFF_E:   return LED_ON_E;
            LED_ON_E:    return LED_BLINK_E;
            LED_BLINK_E: return LED_BREATHE_E;
            default:     return LED_OFF_E;
        endcase
    endfunction

endpackage

// File: rtl/arty_z7_led_if.sv
// Control/status bundle between a button-side driver and one LED core.
// The driver owns the toggle level and duty; the core owns the LED and mode.
interface arty_z7_led_if
    import arty_z7_led_pkg::*;
#(
    parameter int PWM_WIDTH_P = 8
);
    logic                   mode_tgl;
    logic [PWM_WIDTH_P-1:0] duty;
    logic                   led;
    led_mode_t              mode;

    modport master (output mode_tgl, output duty, input led, input mode);
    modport slave  (input mode_tgl, input duty, output led, output mode);
endinterface

// File: rtl/arty_z7_led_pwm.sv
// Free-running PWM for the LED core. Duty is sampled only at the period
// boundary so a mid-period duty change never produces a glitched period.
module led_pwm #(
    parameter int PWM_WIDTH_P = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PWM_WIDTH_P-1:0] duty_in,
    output logic                   period_end,
    output logic [PWM_WIDTH_P-1:0] pwm_cnt,
    output logic                   pwm_on
);
    localparam logic [PWM_WIDTH_P-1:0] PWM_MAX = '1;

    logic [PWM_WIDTH_P-1:0] duty_q;

    assign period_end = (pwm_cnt == PWM_MAX);
    assign pwm_on     = (pwm_cnt < duty_q);

    // Counter wraps naturally; duty is latched on the last count of each period.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            duty_q  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_WIDTH_P'(1);
            if (period_end) begin
                duty_q <= duty_in;
            end
        end
    end

endmodule

// File: rtl/arty_z7_led_core.sv
// One LED driver: each edge of mode_tgl advances OFF/ON/BLINK/BREATHE.
// Optional build macro ARTY_Z7_LED_GAMMA_EN: squares the breathe level
// before it drives the PWM so the fade looks perceptually smoother.
module arty_z7_led_core
    import arty_z7_led_pkg::*;
#(
    parameter int PWM_WIDTH_P         = 8,
    parameter int BLINK_HALF_PERIOD_P = 62500000,
    parameter int BREATHE_STEP_CLKS_P = 244140
) (
    input logic           clk,
    input logic           rst,
    arty_z7_led_if.slave  bus
);
    localparam int BLINK_W = (BLINK_HALF_PERIOD_P > 1) ? $clog2(BLINK_HALF_PERIOD_P) : 1;
    localparam int STEP_W  = (BREATHE_STEP_CLKS_P > 1) ? $clog2(BREATHE_STEP_CLKS_P) : 1;

    localparam logic [BLINK_W-1:0]     BLINK_LAST = BLINK_W'(BLINK_HALF_PERIOD_P - 1);
    localparam logic [STEP_W-1:0]      STEP_LAST  = STEP_W'(BREATHE_STEP_CLKS_P - 1);
    localparam logic [PWM_WIDTH_P-1:0] LEVEL_MAX  = '1;
    localparam logic [PWM_WIDTH_P-1:0] LEVEL_ONE  = PWM_WIDTH_P'(1);

    logic                   tgl_q;
    logic                   adv;
    led_mode_t              mode_q;
    led_mode_t              mode_nxt;
    logic                   led_q;

    logic [BLINK_W-1:0]     blink_cnt;
    logic                   blink_ph;

    logic [STEP_W-1:0]      step_cnt;
    logic [PWM_WIDTH_P-1:0] level;
    logic                   dir_up;
    logic [PWM_WIDTH_P-1:0] breathe_duty;

    logic [PWM_WIDTH_P-1:0] pwm_cnt;
    logic                   pwm_on;
    logic                   breathe_on;

    assign adv      = bus.mode_tgl ^ tgl_q;
    assign mode_nxt = next_mode(mode_q);

`ifdef ARTY_Z7_LED_GAMMA_EN
    logic [2*PWM_WIDTH_P-1:0] level_sq;
    assign level_sq     = {{PWM_WIDTH_P{1'b0}}, level} * {{PWM_WIDTH_P{1'b0}}, level};
    assign breathe_duty = level_sq[2*PWM_WIDTH_P-1:PWM_WIDTH_P];
`else
    assign breathe_duty = level;
`endif

    // Breathe compares the live level directly, not the period-sampled duty.
    assign breathe_on = (pwm_cnt < breathe_duty);

    led_pwm #(
        .PWM_WIDTH_P (PWM_WIDTH_P)
    ) u_pwm (
        .clk        (clk),
        .rst        (rst),
        .duty_in    (bus.duty),
        .period_end (),
        .pwm_cnt    (pwm_cnt),
        .pwm_on     (pwm_on)
    );

    // Toggle edge detection, mode FSM and the registered LED drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            tgl_q  <= bus.mode_tgl;
            mode_q <= LED_OFF_E;
            led_q  <= 1'b0;
        end else begin
            tgl_q <= bus.mode_tgl;
            if (adv) begin
                mode_q <= mode_nxt;
            end
            case (mode_q)
                LED_ON_E:      led_q <= pwm_on;
                LED_BLINK_E:   led_q <= pwm_on & blink_ph;
                LED_BREATHE_E: led_q <= breathe_on;
                default:       led_q <= 1'b0;
            endcase
        end
    end

    // Blink half-period timer; restarts lit on entry and freezes when inactive.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b1;
        end else if (adv && (mode_nxt == LED_BLINK_E)) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b1;
        end else if (mode_q == LED_BLINK_E) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    // Breathe triangle: one level step per step period, each endpoint held one step.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt <= '0;
            level    <= '0;
            dir_up   <= 1'b1;
        end else if (adv && (mode_nxt == LED_BREATHE_E)) begin
            step_cnt <= '0;
            level    <= '0;
            dir_up   <= 1'b1;
        end else if (mode_q == LED_BREATHE_E) begin
            if (step_cnt == STEP_LAST) begin
                step_cnt <= '0;
                if (dir_up) begin
                    level <= level + LEVEL_ONE;
                    if (level == (LEVEL_MAX - LEVEL_ONE)) begin
                        dir_up <= 1'b0;
                    end
                end else begin
                    level <= level - LEVEL_ONE;
                    if (level == LEVEL_ONE) begin
                        dir_up <= 1'b1;
                    end
                end
            end else begin
                step_cnt <= step_cnt + STEP_W'(1);
            end
        end
    end

    assign bus.led  = led_q;
    assign bus.mode = mode_q;

endmodule

// File: tb/tb_arty_z7_led_core.sv
// Directed bench for arty_z7_led_core with a 4-bit PWM, 10-clk blink
// half-period and 16-clk breathe step. Expected values are derived from
// a bench-side copy of the PWM phase (known from the reset release).
module tb_arty_z7_led_core;
    import arty_z7_led_pkg::*;

    localparam int W = 4;
    localparam int H = 10;
    localparam int S = 16;

    logic clk = 1'b0;
    logic rst;

    int errCount   = 0;
    int checkCount = 0;
    int pcnt       = 0;
    int pcntPrev   = 0;

    always #5 clk = ~clk;

    arty_z7_led_if #(.PWM_WIDTH_P(W)) led_bus ();

    arty_z7_led_core #(
        .PWM_WIDTH_P         (W),
        .BLINK_HALF_PERIOD_P (H),
        .BREATHE_STEP_CLKS_P (S)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (led_bus)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One clock; tracks the PWM counter value that the DUT just used for led.
    task automatic tick();
        logic r;
        r = rst;
        @(posedge clk);
        #1;
        pcntPrev = pcnt;
        if (r) pcnt = 0;
        else   pcnt = (pcnt + 1) % (1 << W);
    endtask

    // Optionally flips the toggle level, then advances one clock.
    task automatic applyStimulus(input logic flip);
        if (flip) led_bus.mode_tgl = ~led_bus.mode_tgl;
        tick();
    endtask

    // Counts led-high clocks over n clocks, plus how many of them the PWM
    // alone would light for a given duty.
    task automatic runWindow(input int n, input int refDuty, output int highs, output int pwmHighs);
        highs    = 0;
        pwmHighs = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (led_bus.led === 1'b1) highs++;
            if (pcntPrev < refDuty)   pwmHighs++;
        end
    endtask

    function automatic int breatheExpected(input int period);
        int p;
        int lvl;
        p   = period % 30;
        lvl = (p <= 15) ? p : 30 - p;
`ifdef ARTY_Z7_LED_GAMMA_EN
        return (lvl * lvl) >> W;
`else
        return lvl;
`endif
    endfunction

    initial begin
        int h;
        int p;
        int dutyList[3];
        dutyList[0] = 0;
        dutyList[1] = 8;
        dutyList[2] = 15;

        rst              = 1'b1;
        led_bus.mode_tgl = 1'b1;
        led_bus.duty     = '0;
        repeat (3) tick();
        rst = 1'b0;

        checkOutput("rst_mode", 32'(led_bus.mode), 0);
        checkOutput("rst_led", 32'(led_bus.led), 0);

        // Toggle held high through reset must not count as an edge.
        runWindow(100, 0, h, p);
        checkOutput("hold_led_highs", h, 0);
        checkOutput("hold_mode", 32'(led_bus.mode), 0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1);
            checkOutput($sformatf("flip%0d_mode", i), 32'(led_bus.mode), (i + 1) % 4);
            repeat (4) applyStimulus(1'b0);
        end

        applyStimulus(1'b1);
        checkOutput("on_entry_mode", 32'(led_bus.mode), 1);

        for (int k = 0; k < 3; k++) begin
            led_bus.duty = W'(dutyList[k]);
            repeat (32) applyStimulus(1'b0);
            runWindow(16, 0, h, p);
            checkOutput($sformatf("on_duty%0d_highs", dutyList[k]), h, dutyList[k]);
        end

        // Duty change at pwm_cnt=5 must not affect the rest of that period.
        led_bus.duty = W'(8);
        repeat (32) applyStimulus(1'b0);
        for (int i = 0; i < 16 && pcnt != 5; i++) tick();
        led_bus.duty = W'(2);
        runWindow(11, 0, h, p);
        checkOutput("mid_period_old_ratio", h, 3);
        runWindow(16, 0, h, p);
        checkOutput("mid_period_new_ratio", h, 2);

        applyStimulus(1'b1);
        checkOutput("b2b_first_mode", 32'(led_bus.mode), 2);
        applyStimulus(1'b1);
        checkOutput("b2b_second_mode", 32'(led_bus.mode), 3);

        applyStimulus(1'b1);
        applyStimulus(1'b1);
        led_bus.duty = W'(15);
        repeat (32) applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("blink_entry_mode", 32'(led_bus.mode), 2);

        for (int w = 0; w < 4; w++) begin
            runWindow(H, 15, h, p);
            checkOutput($sformatf("blink_window%0d_highs", w), h, (w % 2 == 0) ? p : 0);
        end

        // Leave BLINK in its dark half, cycle round, and expect a lit restart.
        repeat (15) tick();
        repeat (4) applyStimulus(1'b1);
        checkOutput("blink_reentry_mode", 32'(led_bus.mode), 2);
        runWindow(H, 15, h, p);
        checkOutput("blink_reentry_lit_highs", h, p);

        // Enter BREATHE on a PWM period boundary so each period sees one level.
        for (int i = 0; i < 16 && pcnt != 15; i++) tick();
        applyStimulus(1'b1);
        checkOutput("breathe_entry_mode", 32'(led_bus.mode), 3);
        for (int j = 0; j < 32; j++) begin
            runWindow(16, 0, h, p);
            checkOutput($sformatf("breathe_period%0d_highs", j), h, breatheExpected(j));
        end

        // Reset wins over a simultaneous toggle edge.
        rst = 1'b1;
        led_bus.mode_tgl = ~led_bus.mode_tgl;
        tick();
        checkOutput("rst_mid_mode", 32'(led_bus.mode), 0);
        checkOutput("rst_mid_led", 32'(led_bus.led), 0);
        rst = 1'b0;
        tick();
        checkOutput("post_rst_mode", 32'(led_bus.mode), 0);
        checkOutput("post_rst_led", 32'(led_bus.led), 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
